// File: rtl/spi_slave_fsm.sv
// SPI mode-0 slave transaction controller: decodes an address/RW header from
// conditioned pad signals, then performs a single memory write or a serial read.
module spi_slave_fsm #(
    parameter int unsigned addrwidth  = 7,
    parameter int unsigned datawidth  = 8,
    parameter int unsigned countwidth = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs_cond,
    input  logic                 sclk_posedge,
    input  logic                 sclk_negedge,
    input  logic                 mosi_cond,
    input  logic [datawidth-1:0] mem_rdata,
    output logic [addrwidth-1:0] mem_addr,
    output logic [datawidth-1:0] mem_wdata,
    output logic                 mem_we,
    output logic                 miso_out,
    output logic                 miso_bufe
);

    localparam int unsigned rxwidth = (addrwidth + 1 > datawidth) ? addrwidth + 1 : datawidth;
    localparam logic [countwidth-1:0] hdr_bits  = countwidth'(addrwidth + 1);
    localparam logic [countwidth-1:0] data_bits = countwidth'(datawidth);

    typedef enum logic [2:0] {
        S_WAIT,
        S_IDLE,
        S_GET_ADDR,
        S_DECODE,
        S_READ_LOAD,
        S_READ_SHIFT,
        S_WRITE_SHIFT,
        S_WRITE_MEM
    } state_t;

    state_t                 state, state_nxt;
    logic [countwidth-1:0]  cnt, cnt_nxt, cnt_inc;
    logic [rxwidth-1:0]     rx, rx_nxt, rx_shift;
    logic [datawidth-1:0]   tx, tx_nxt;
    logic                   rw, rw_nxt;
    logic [addrwidth-1:0]   addr_nxt;
    logic [datawidth-1:0]   wdata_nxt;
    logic                   we_nxt, miso_nxt, bufe_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_WAIT;
            cnt       <= '0;
            rx        <= '0;
            tx        <= '0;
            rw        <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            miso_out  <= 1'b0;
            miso_bufe <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rx        <= rx_nxt;
            tx        <= tx_nxt;
            rw        <= rw_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_we    <= we_nxt;
            miso_out  <= miso_nxt;
            miso_bufe <= bufe_nxt;
        end
    end

    // Next-state and next-output logic; a high CS aborts every active state but WRITE_MEM
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rx_nxt    = rx;
        tx_nxt    = tx;
        rw_nxt    = rw;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        miso_nxt  = miso_out;
        rx_shift  = {rx[rxwidth-2:0], mosi_cond};
        cnt_inc   = cnt + countwidth'(1);

        case (state)
            S_WAIT: begin
                if (cs_cond) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!cs_cond) begin
                    state_nxt = S_GET_ADDR;
                    cnt_nxt   = '0;
                end
            end
            S_GET_ADDR: begin
                if (cs_cond) begin
                    state_nxt = S_WAIT;
                end else if (sclk_posedge) begin
                    rx_nxt  = rx_shift;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == hdr_bits) begin
                        state_nxt = S_DECODE;
                        addr_nxt  = rx_shift[addrwidth:1];
                        rw_nxt    = rx_shift[0];
                        cnt_nxt   = '0;
                    end
                end
            end
            S_DECODE: begin
                if (cs_cond)  state_nxt = S_WAIT;
                else if (rw)  state_nxt = S_READ_LOAD;
                else          state_nxt = S_WRITE_SHIFT;
            end
            S_READ_LOAD: begin
                if (cs_cond) begin
                    state_nxt = S_WAIT;
                end else begin
                    tx_nxt    = mem_rdata;
                    state_nxt = S_READ_SHIFT;
                end
            end
            S_READ_SHIFT: begin
                if (cs_cond) begin
                    state_nxt = S_WAIT;
                end else begin
                    if (sclk_negedge) begin
                        miso_nxt = tx[datawidth-1];
                        tx_nxt   = {tx[datawidth-2:0], 1'b0};
                    end
                    if (sclk_posedge) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == data_bits) begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = '0;
                        end
                    end
                end
            end
            S_WRITE_SHIFT: begin
                if (cs_cond) begin
                    state_nxt = S_WAIT;
                end else if (sclk_posedge) begin
                    rx_nxt  = rx_shift;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == data_bits) begin
                        state_nxt = S_WRITE_MEM;
                        wdata_nxt = rx_shift[datawidth-1:0];
                        cnt_nxt   = '0;
                    end
                end
            end
            S_WRITE_MEM: begin
                state_nxt = S_WAIT;
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase

        // Registered strobes follow the state being entered so they align with it
        we_nxt   = (state_nxt == S_WRITE_MEM);
        bufe_nxt = (state_nxt == S_READ_LOAD) || (state_nxt == S_READ_SHIFT);
        if (!bufe_nxt) miso_nxt = 1'b0;
    end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Randomized self-checking bench for spi_slave_fsm against a transaction-level
// memory model (expected contents kept separately from the DUT-written memory).
module tb_spi_slave_fsm;

    localparam int AW = 7;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs_cond;
    logic          sclk_posedge;
    logic          sclk_negedge;
    logic          mosi_cond;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          miso_out;
    logic          miso_bufe;

    bit   [DW-1:0] mem     [0:127];
    bit   [DW-1:0] ref_mem [0:127];

    int n_tests = 0;
    int n_fail  = 0;

    int            we_count    = 0;
    int            we_double   = 0;
    int            bufe_cycles = 0;
    logic          we_prev     = 1'b0;
    logic [AW-1:0] last_addr   = '0;
    logic [DW-1:0] last_data   = '0;

    spi_slave_fsm #(.addrwidth(AW), .datawidth(DW), .countwidth(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cs_cond      (cs_cond),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .mosi_cond    (mosi_cond),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .miso_out     (miso_out),
        .miso_bufe    (miso_bufe)
    );

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    // Environment memory plus write/enable activity counters
    always @(posedge clk) begin
        if (mem_we) begin
            we_count++;
            last_addr = mem_addr;
            last_data = mem_wdata;
            mem[mem_addr] = mem_wdata;
            if (we_prev) we_double++;
        end
        we_prev = mem_we;
        if (miso_bufe) bufe_cycles++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCLK period: MOSI set, rising pulse, then falling pulse; samples MISO after the fall
    task automatic sclk_cycle(input logic m, output logic miso_s, output logic bufe_s);
        mosi_cond = m;
        idle(2);
        sclk_posedge = 1'b1;
        idle(1);
        sclk_posedge = 1'b0;
        idle(2);
        sclk_negedge = 1'b1;
        idle(1);
        sclk_negedge = 1'b0;
        miso_s = miso_out;
        bufe_s = miso_bufe;
        idle(1);
    endtask

    task automatic start_frame(input bit glitch);
        cs_cond = 1'b1;
        idle(2);
        cs_cond = 1'b0;
        if (glitch) begin
            mosi_cond    = 1'b1;
            sclk_posedge = 1'b1;
        end
        idle(1);
        sclk_posedge = 1'b0;
    endtask

    task automatic send_header(input logic [AW-1:0] a, input logic rw,
                               output logic miso_s, output logic bufe_s);
        logic m, b;
        for (int i = AW - 1; i >= 0; i--) sclk_cycle(a[i], m, b);
        sclk_cycle(rw, miso_s, bufe_s);
    endtask

    task automatic send_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input bit glitch, input bit raise_cs);
        logic m, b;
        start_frame(glitch);
        send_header(a, 1'b0, m, b);
        for (int i = DW - 1; i >= 0; i--) sclk_cycle(d[i], m, b);
        idle(2);
        if (raise_cs) begin
            cs_cond = 1'b1;
            idle(2);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] q,
                           output logic bufe_during, output logic bufe_after);
        logic m, b;
        start_frame(1'b0);
        send_header(a, 1'b1, m, b);
        q[DW-1]     = m;
        bufe_during = b;
        for (int i = 0; i < DW; i++) begin
            sclk_cycle(1'($urandom_range(0, 1)), m, b);
            if (i < DW - 1) begin
                q[DW-2-i]   = m;
                bufe_during = bufe_during & b;
            end else begin
                bufe_after = b;
            end
        end
        idle(2);
        cs_cond = 1'b1;
        idle(2);
    endtask

    // Write then check the single resulting strobe against the model
    task automatic write_and_check(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit glitch);
        int we0, b0, dbl0;
        we0 = we_count; b0 = bufe_cycles; dbl0 = we_double;
        send_write(a, d, glitch, 1'b1);
        ref_mem[a] = d;
        n_tests++;
        if (we_count - we0 !== 1) begin
            n_fail++; $display("FAIL write_we_count a=%0h: got %0d pulses, expected 1", a, we_count - we0);
        end
        n_tests++;
        if (last_addr !== a || last_data !== d) begin
            n_fail++; $display("FAIL write_payload: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                               last_addr, last_data, a, d);
        end
        n_tests++;
        if (bufe_cycles !== b0 || we_double !== dbl0) begin
            n_fail++; $display("FAIL write_side_effects: bufe cycles %0d double_we %0d, expected 0 and 0",
                               bufe_cycles - b0, we_double - dbl0);
        end
    endtask

    task automatic read_and_check(input logic [AW-1:0] a);
        logic [DW-1:0] q;
        logic bd, ba;
        int we0;
        we0 = we_count;
        do_read(a, q, bd, ba);
        n_tests++;
        if (q !== ref_mem[a]) begin
            n_fail++; $display("FAIL read_data a=%0h: got %0h, expected %0h", a, q, ref_mem[a]);
        end
        n_tests++;
        if (bd !== 1'b1 || ba !== 1'b0) begin
            n_fail++; $display("FAIL read_bufe a=%0h: during=%b after=%b, expected 1 and 0", a, bd, ba);
        end
        n_tests++;
        if (we_count !== we0) begin
            n_fail++; $display("FAIL read_no_write: got %0d pulses, expected 0", we_count - we0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; cs_cond = 1'b0; sclk_posedge = 1'b1; sclk_negedge = 1'b1; mosi_cond = 1'b1;
        idle(3);
        sclk_posedge = 1'b0; sclk_negedge = 1'b0; mosi_cond = 1'b0; cs_cond = 1'b1;
        n_tests++;
        if (mem_we !== 1'b0 || miso_bufe !== 1'b0 || miso_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: we=%b bufe=%b miso=%b, expected 0 0 0", mem_we, miso_bufe, miso_out);
        end
        n_tests++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_regs: addr=%0h wdata=%0h, expected 0 0", mem_addr, mem_wdata);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_write;
        write_and_check(7'h15, 8'hA5, 1'b0);
        write_and_check(7'h2A, 8'h5A, 1'b1);
        for (int i = 0; i < 6; i++)
            write_and_check(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_read;
        logic [AW-1:0] a;
        read_and_check(7'h15);
        for (int i = 0; i < 5; i++) begin
            a = 7'($urandom_range(0, 127));
            write_and_check(a, 8'($urandom_range(0, 255)), 1'b0);
            read_and_check(a);
            read_and_check(7'($urandom_range(0, 127)));
        end
    endtask

    task automatic test_abort;
        logic m, b;
        int we0, k;
        we0 = we_count;
        start_frame(1'b0);
        send_header(7'h02, 1'b0, m, b);
        for (int i = 0; i < 4; i++) sclk_cycle(1'b1, m, b);
        cs_cond = 1'b1;
        idle(3);
        n_tests++;
        if (we_count !== we0) begin
            n_fail++; $display("FAIL abort_write: got %0d pulses, expected 0", we_count - we0);
        end
        write_and_check(7'h03, 8'h3C, 1'b0);

        // Abort mid-header at a random bit
        we0 = we_count;
        k = $urandom_range(1, AW);
        start_frame(1'b0);
        for (int i = 0; i < k; i++) sclk_cycle(1'($urandom_range(0, 1)), m, b);
        cs_cond = 1'b1;
        idle(3);
        n_tests++;
        if (we_count !== we0 || miso_bufe !== 1'b0) begin
            n_fail++; $display("FAIL abort_header k=%0d: pulses %0d bufe %b, expected 0 0", k, we_count - we0, miso_bufe);
        end

        // Abort mid-read drops the enable on the next clock
        start_frame(1'b0);
        send_header(7'h15, 1'b1, m, b);
        sclk_cycle(1'b0, m, b);
        cs_cond = 1'b1;
        idle(1);
        n_tests++;
        if (miso_bufe !== 1'b0) begin
            n_fail++; $display("FAIL abort_read_bufe: got %b, expected 0", miso_bufe);
        end
        idle(2);
        read_and_check(7'h03);
    endtask

    task automatic test_trailing;
        logic m, b;
        int we0, b0;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = 7'($urandom_range(0, 127));
        d = 8'($urandom_range(0, 255));
        we0 = we_count;
        send_write(a, d, 1'b0, 1'b0);
        ref_mem[a] = d;
        b0 = bufe_cycles;
        for (int i = 0; i < 5; i++) sclk_cycle(1'($urandom_range(0, 1)), m, b);
        n_tests++;
        if (we_count - we0 !== 1 || bufe_cycles !== b0) begin
            n_fail++; $display("FAIL trailing_clocks: pulses %0d bufe cycles %0d, expected 1 0", we_count - we0, bufe_cycles - b0);
        end
        cs_cond = 1'b1;
        idle(2);
        write_and_check(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic test_reset_mid_read;
        logic m, b;
        int we0, b0;
        logic [AW-1:0] a;
        a = 7'h15;
        ref_mem[a] = 8'hFF;
        write_and_check(a, 8'hFF, 1'b0);
        start_frame(1'b0);
        send_header(a, 1'b1, m, b);
        for (int i = 0; i < 3; i++) sclk_cycle(1'b0, m, b);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        n_tests++;
        if (miso_bufe !== 1'b0 || miso_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_read: bufe=%b miso=%b, expected 0 0", miso_bufe, miso_out);
        end
        we0 = we_count; b0 = bufe_cycles;
        for (int i = 0; i < DW + AW + 1; i++) sclk_cycle(1'($urandom_range(0, 1)), m, b);
        n_tests++;
        if (we_count !== we0 || bufe_cycles !== b0) begin
            n_fail++; $display("FAIL post_reset_ignore: pulses %0d bufe cycles %0d, expected 0 0", we_count - we0, bufe_cycles - b0);
        end
        cs_cond = 1'b1;
        idle(2);
        read_and_check(a);
    endtask

    task automatic test_back_to_back;
        write_and_check(7'h7F, 8'h7F, 1'b0);
        read_and_check(7'h7F);
    endtask

    initial begin
        reset = 1'b1; cs_cond = 1'b1; sclk_posedge = 1'b0; sclk_negedge = 1'b0; mosi_cond = 1'b0;
        idle(1);
        test_reset;
        test_write;
        test_read;
        test_abort;
        test_trailing;
        test_reset_mid_read;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
